// File: rtl/fuzzy_pkg.sv
// Shared fixed-point types and helpers for the fuzzy temperature-control pipeline.
package fuzzy_pkg;

  typedef logic signed [7:0] q7_t;

  localparam int Q7_MAX = 127;
  localparam int Q7_MIN = -128;

  // True when a 9-bit intermediate falls outside the Q7.0 range.
  function automatic logic is_sat_q7(input logic signed [8:0] v);
    return (v > 9'sd127) || (v < -9'sd128);
  endfunction

  // Clip a 9-bit signed intermediate to the Q7.0 range.
  function automatic q7_t sat_q7(input logic signed [8:0] v);
    q7_t r;
    if (v > 9'sd127)       r = 8'sh7f;
    else if (v < -9'sd128) r = 8'sh80;
    else                   r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/dt_estimator.sv
// Temperature rate-of-change estimator: T[n] - T[n-DEPTH], scaled by 2^-SHIFT
// and saturated to Q7.0. Feeds the dT fuzzifier; dt_valid marks fresh output.
module dt_estimator
  import fuzzy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample_valid,
  input  q7_t  temp_in,
  output q7_t  dt_out,
  output logic dt_valid,
  output logic dt_sat,
  output logic primed
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  q7_t           hist_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  q7_t           dt_out_q, dt_out_d;
  logic          dt_valid_q, dt_valid_d;
  logic          dt_sat_q, dt_sat_d;

  logic              accept;
  q7_t               temp_g;
  q7_t               oldest;
  logic signed [8:0] diff;
  logic signed [8:0] scaled;

  // A sample is taken only when no flush is pending; clear discards it.
  assign accept = sample_valid && !clear;
  // Gate the sample so an undriven bus between strobes cannot leak into state.
  assign temp_g = sample_valid ? temp_in : '0;
  assign primed = (cnt_q == CW'(DEPTH));

  // Difference against the oldest entry, floor-divide by 2^SHIFT, then clip.
  always_comb begin
    oldest = hist_q[wr_ptr_q];
    diff   = $signed({temp_g[7], temp_g}) - $signed({oldest[7], oldest});
    scaled = diff >>> SHIFT;
  end

  // Next-state for pointer, fill count and the registered outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    dt_out_d   = dt_out_q;
    dt_valid_d = 1'b0;
    dt_sat_d   = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (accept) begin
      // DEPTH is a power of two, so the pointer wraps by plain overflow.
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (primed) begin
        dt_out_d   = sat_q7(scaled);
        dt_valid_d = 1'b1;
        dt_sat_d   = is_sat_q7(scaled);
      end else begin
        // The sample that completes the window only primes; no output yet.
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      dt_out_q   <= '0;
      dt_valid_q <= 1'b0;
      dt_sat_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      dt_out_q   <= dt_out_d;
      dt_valid_q <= dt_valid_d;
      dt_sat_q   <= dt_sat_d;
    end
  end

  // History ring: the oldest slot is overwritten by each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[wr_ptr_q] <= temp_g;
    end
  end

  assign dt_out   = dt_out_q;
  assign dt_valid = dt_valid_q;
  assign dt_sat   = dt_sat_q;

endmodule

// File: tb/tb_dt_estimator.sv
// Scoreboard bench: two estimators (SHIFT=0 and SHIFT=1) share one stimulus
// stream; a sliding-window model predicts each dT and a negedge monitor checks.
module tb_dt_estimator;
  import fuzzy_pkg::*;

  localparam int DEPTH = 4;

  typedef struct { int dt; bit sat; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  q7_t  temp_in = '0;

  q7_t  dt_out0, dt_out1;
  logic dt_valid0, dt_valid1, dt_sat0, dt_sat1, primed0, primed1;

  int   n_cmp = 0;
  int   n_err = 0;
  int   vcnt0 = 0;
  int   hist[$];
  exp_t e0[$];
  exp_t e1[$];

  always #5 clk = ~clk;

  dt_estimator #(.DEPTH(DEPTH), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .temp_in(temp_in), .dt_out(dt_out0), .dt_valid(dt_valid0),
    .dt_sat(dt_sat0), .primed(primed0)
  );

  dt_estimator #(.DEPTH(DEPTH), .SHIFT(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .temp_in(temp_in), .dt_out(dt_out1), .dt_valid(dt_valid1),
    .dt_sat(dt_sat1), .primed(primed1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: difference of the new sample and the one DEPTH samples back.
  function automatic exp_t predict(input int t, input int old, input int s);
    exp_t e;
    int   d;
    d = t - old;
    d = d >>> s;  // floor division by 2^s on a signed int
    e.sat = (d > Q7_MAX) || (d < Q7_MIN);
    e.dt  = (d > Q7_MAX) ? Q7_MAX : (d < Q7_MIN) ? Q7_MIN : d;
    return e;
  endfunction

  // One cycle: check primed, then drive inputs for the coming edge.
  task automatic step(input bit sv, input int t, input bit clr);
    @(negedge clk); #1;
    chk("primed0", int'(primed0), int'(hist.size() == DEPTH));
    chk("primed1", int'(primed1), int'(hist.size() == DEPTH));
    sample_valid = sv;
    clear        = clr;
    temp_in      = sv ? q7_t'(t) : q7_t'($urandom_range(0, 255));
    if (clr) begin
      hist.delete();
    end else if (sv) begin
      if (hist.size() == DEPTH) begin
        e0.push_back(predict(t, hist[0], 0));
        e1.push_back(predict(t, hist[0], 1));
        void'(hist.pop_front());
      end
      hist.push_back(t);
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must fall before any edge.
  task automatic async_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    sample_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("rst_dt_out", int'(dt_out0), 0);
    chk("rst_dt_valid", int'(dt_valid0), 0);
    chk("rst_dt_sat", int'(dt_sat0), 0);
    chk("rst_primed", int'(primed0), 0);
    chk("rst_primed1", int'(primed1), 0);
    hist.delete();
    e0.delete();
    e1.delete();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every dt_valid pops one prediction; stray pulses are errors.
  always @(negedge clk) begin
    if (!rst) begin
      if (dt_valid0) begin
        vcnt0++;
        if (e0.size() == 0) begin
          chk("dut0_unexpected_valid", 1, 0);
        end else begin
          exp_t x;
          x = e0.pop_front();
          chk("dut0_dt_out", int'(dt_out0), x.dt);
          chk("dut0_dt_sat", int'(dt_sat0), int'(x.sat));
        end
      end else begin
        chk("dut0_sat_without_valid", int'(dt_sat0), 0);
      end
      if (dt_valid1) begin
        if (e1.size() == 0) begin
          chk("dut1_unexpected_valid", 1, 0);
        end else begin
          exp_t x;
          x = e1.pop_front();
          chk("dut1_dt_out", int'(dt_out1), x.dt);
          chk("dut1_dt_sat", int'(dt_sat1), int'(x.sat));
        end
      end else begin
        chk("dut1_sat_without_valid", int'(dt_sat1), 0);
      end
    end
  end

  initial begin
    int v0;
    int held;
    #2;
    chk("init_dt_out", int'(dt_out0), 0);
    chk("init_dt_valid", int'(dt_valid0), 0);
    chk("init_dt_sat", int'(dt_sat0), 0);
    chk("init_primed", int'(primed0), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Prime with a flat signal, then a step of +10.
    for (int i = 0; i < 4; i++) step(1'b1, 10, 1'b0);
    step(1'b1, 20, 1'b0);
    idle();
    chk("prime_step_dt", int'(dt_out0), 10);
    idle();

    // Back-to-back ramp after reset: seven consecutive differences of 20.
    async_reset();
    v0 = vcnt0;
    for (int i = 0; i <= 10; i++) step(1'b1, 5 * i, 1'b0);
    idle(); idle();
    chk("ramp_valid_count", vcnt0 - v0, 7);
    chk("ramp_dt", int'(dt_out0), 20);

    // Saturation in both directions.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, -100, 1'b0);
    step(1'b1, 100, 1'b0);
    idle();
    chk("sat_pos_dt", int'(dt_out0), 127);
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 100, 1'b0);
    step(1'b1, -100, 1'b0);
    idle();
    chk("sat_neg_dt", int'(dt_out0), -128);

    // Clear colliding with a sample: sample dropped, output held.
    held = int'(dt_out0);
    step(1'b1, 50, 1'b1);
    idle();
    chk("clear_hold_dt", int'(dt_out0), held);
    for (int i = 0; i < 4; i++) step(1'b1, 3 * i, 1'b0);
    step(1'b1, 40, 1'b0);
    idle();
    chk("clear_reprime_dt", int'(dt_out0), 40);

    // Floor rounding with SHIFT=1 on the second instance.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b0);
    idle();
    chk("shift_neg_dt", int'(dt_out1), -4);
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0);
    step(1'b1, 7, 1'b0);
    idle();
    chk("shift_pos_dt", int'(dt_out1), 3);

    // Mid-stream async reset, then full re-prime.
    for (int i = 0; i < 3; i++) step(1'b1, i * 11, 1'b0);
    async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i * 9 - 20, 1'b0);
    idle();

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
             $urandom_range(0, 39) == 0);
      end
    end
    idle(); idle(); idle();
    chk("dut0_pending", e0.size(), 0);
    chk("dut1_pending", e1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
